// File: rtl/idu_rf_pkg.sv
// Shared defaults and payload types for the IDU register-file read stage.
// Control fields have fixed widths, so they travel together as one packed struct.
package idu_rf_pkg;

    localparam int DEF_XLEN   = 64;
    localparam int DEF_PREG_W = 6;
    localparam int DEF_IID_W  = 4;
    localparam int DEF_NSRC   = 2;
    localparam int DEF_NFWD   = 8;
    localparam int PC_W       = 64;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [PC_W-1:0] pc;
    } idu_rf_ctrl_t;

endpackage

// File: rtl/idu_rf_bypass_mux.sv
// Operand resolution for one source: captured value, else lowest-index matching
// bypass bus, else register-file read data.
module idu_rf_bypass_mux
    import idu_rf_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int PREG_W = DEF_PREG_W,
    parameter int NFWD   = DEF_NFWD
) (
    input  logic                   src_vld,
    input  logic [PREG_W-1:0]      src_preg,
    input  logic [NFWD-1:0]        fwd_vld,
    input  logic [NFWD*PREG_W-1:0] fwd_preg,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [XLEN-1:0]        rf_data,
    input  logic                   cap_flag,
    input  logic [XLEN-1:0]        cap_data,
    output logic [XLEN-1:0]        src_data
);

    logic [NFWD-1:0] hit;
    logic [XLEN-1:0] sel_data;

    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_hit
            assign hit[gi] = fwd_vld[gi] & src_vld
                           & (fwd_preg[gi*PREG_W +: PREG_W] == src_preg);
        end
    endgenerate

    // Walk from the lowest priority upward so bus 0 overrides everything else.
    always_comb begin
        sel_data = rf_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel_data = fwd_data[k*XLEN +: XLEN];
            end
        end
    end

    assign src_data = cap_flag ? cap_data : sel_data;

endmodule

// File: rtl/idu_rf_stage.sv
// Register-file read stage: registers the issued instruction, reads the RF,
// resolves operands through the bypass network and freezes them on a stall.
module idu_rf_stage
    import idu_rf_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int PREG_W = DEF_PREG_W,
    parameter int IID_W  = DEF_IID_W,
    parameter int NSRC   = DEF_NSRC,
    parameter int NFWD   = DEF_NFWD
) (
    input  logic                   clk,
    input  logic                   rst_clk,
    input  logic                   rtu_global_flush,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [IID_W-1:0]       in_iid,
    input  logic [6:0]             in_opcode,
    input  logic [6:0]             in_funct7,
    input  logic [2:0]             in_funct3,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [NSRC-1:0]        in_psrc_vld,
    input  logic [NSRC*PREG_W-1:0] in_psrc,
    input  logic                   in_pdst_vld,
    input  logic [PREG_W-1:0]      in_pdst,
    input  logic                   in_imm_vld,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [NFWD-1:0]        fwd_vld,
    input  logic [NFWD*PREG_W-1:0] fwd_preg,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic [NSRC-1:0]        rf_rd_vld,
    output logic [NSRC*PREG_W-1:0] rf_rd_preg,
    input  logic [NSRC*XLEN-1:0]   rf_rd_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [IID_W-1:0]       out_iid,
    output logic [6:0]             out_opcode,
    output logic [6:0]             out_funct7,
    output logic [2:0]             out_funct3,
    output logic [PC_W-1:0]        out_pc,
    output logic [NSRC-1:0]        out_psrc_vld,
    output logic [NSRC*XLEN-1:0]   out_psrc_data,
    output logic                   out_pdst_vld,
    output logic [PREG_W-1:0]      out_pdst,
    output logic                   out_imm_vld,
    output logic [XLEN-1:0]        out_imm,
    output logic                   wake_vld,
    output logic [PREG_W-1:0]      wake_preg
);

    logic                   out_vld_reg;
    logic [IID_W-1:0]       iid_reg;
    idu_rf_ctrl_t           ctrl_reg;
    logic [NSRC-1:0]        psrc_vld_reg;
    logic [NSRC*PREG_W-1:0] psrc_reg;
    logic                   pdst_vld_reg;
    logic [PREG_W-1:0]      pdst_reg;
    logic                   imm_vld_reg;
    logic [XLEN-1:0]        imm_reg;

    logic load;
    logic unload;
    logic stall;

    assign in_rdy = ~out_vld_reg | out_rdy;
    assign load   = in_vld & in_rdy;
    assign unload = out_vld_reg & out_rdy;
    assign stall  = out_vld_reg & ~out_rdy;

    // Flush beats load; an unload without a replacement leaves an all-zero bubble.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            out_vld_reg  <= 1'b0;
            iid_reg      <= '0;
            ctrl_reg     <= '0;
            psrc_vld_reg <= '0;
            psrc_reg     <= '0;
            pdst_vld_reg <= 1'b0;
            pdst_reg     <= '0;
            imm_vld_reg  <= 1'b0;
            imm_reg      <= '0;
        end else if (rtu_global_flush || (unload && !load)) begin
            out_vld_reg  <= 1'b0;
            iid_reg      <= '0;
            ctrl_reg     <= '0;
            psrc_vld_reg <= '0;
            psrc_reg     <= '0;
            pdst_vld_reg <= 1'b0;
            pdst_reg     <= '0;
            imm_vld_reg  <= 1'b0;
            imm_reg      <= '0;
        end else if (load) begin
            out_vld_reg     <= 1'b1;
            iid_reg         <= in_iid;
            ctrl_reg.opcode <= in_opcode;
            ctrl_reg.funct7 <= in_funct7;
            ctrl_reg.funct3 <= in_funct3;
            ctrl_reg.pc     <= in_pc;
            psrc_vld_reg    <= in_psrc_vld;
            psrc_reg        <= in_psrc;
            pdst_vld_reg    <= in_pdst_vld;
            pdst_reg        <= in_pdst;
            imm_vld_reg     <= in_imm_vld;
            imm_reg         <= in_imm;
        end
    end

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic            cap_flag_reg;
            logic [XLEN-1:0] cap_data_reg;
            logic [XLEN-1:0] src_data;

            idu_rf_bypass_mux #(
                .XLEN   (XLEN),
                .PREG_W (PREG_W),
                .NFWD   (NFWD)
            ) u_mux (
                .src_vld  (psrc_vld_reg[gi]),
                .src_preg (psrc_reg[gi*PREG_W +: PREG_W]),
                .fwd_vld  (fwd_vld),
                .fwd_preg (fwd_preg),
                .fwd_data (fwd_data),
                .rf_data  (rf_rd_data[gi*XLEN +: XLEN]),
                .cap_flag (cap_flag_reg),
                .cap_data (cap_data_reg),
                .src_data (src_data)
            );

            // Freeze the operand on the first stalled edge; bypass results are one-shot.
            always_ff @(posedge clk or negedge rst_clk) begin
                if (!rst_clk) begin
                    cap_flag_reg <= 1'b0;
                    cap_data_reg <= '0;
                end else if (rtu_global_flush || load || unload) begin
                    cap_flag_reg <= 1'b0;
                    cap_data_reg <= '0;
                end else if (stall && !cap_flag_reg) begin
                    cap_flag_reg <= 1'b1;
                    cap_data_reg <= src_data;
                end
            end

            assign out_psrc_data[gi*XLEN +: XLEN] = src_data;
        end
    endgenerate

    assign rf_rd_vld    = psrc_vld_reg;
    assign rf_rd_preg   = psrc_reg;
    assign out_vld      = out_vld_reg;
    assign out_iid      = iid_reg;
    assign out_opcode   = ctrl_reg.opcode;
    assign out_funct7   = ctrl_reg.funct7;
    assign out_funct3   = ctrl_reg.funct3;
    assign out_pc       = ctrl_reg.pc;
    assign out_psrc_vld = psrc_vld_reg;
    assign out_pdst_vld = pdst_vld_reg;
    assign out_pdst     = pdst_reg;
    assign out_imm_vld  = imm_vld_reg;
    assign out_imm      = imm_reg;
    assign wake_vld     = out_vld_reg & pdst_vld_reg & out_rdy;
    assign wake_preg    = pdst_reg;

endmodule

// File: tb/tb_idu_rf_stage.sv
// Scoreboard bench for idu_rf_stage: a behavioural stage model predicts every
// handoff to the EXU; a monitor compares the DUT's handoffs against the queue.
module tb_idu_rf_stage;
    import idu_rf_pkg::*;

    localparam int XLEN   = DEF_XLEN;
    localparam int PREG_W = DEF_PREG_W;
    localparam int IID_W  = DEF_IID_W;
    localparam int NSRC   = DEF_NSRC;
    localparam int NFWD   = DEF_NFWD;

    logic                   clk = 1'b0;
    logic                   rst_clk = 1'b0;
    logic                   rtu_global_flush;
    logic                   in_vld;
    logic                   in_rdy;
    logic [IID_W-1:0]       in_iid;
    logic [6:0]             in_opcode, in_funct7;
    logic [2:0]             in_funct3;
    logic [PC_W-1:0]        in_pc;
    logic [NSRC-1:0]        in_psrc_vld;
    logic [NSRC*PREG_W-1:0] in_psrc;
    logic                   in_pdst_vld;
    logic [PREG_W-1:0]      in_pdst;
    logic                   in_imm_vld;
    logic [XLEN-1:0]        in_imm;
    logic [NFWD-1:0]        fwd_vld;
    logic [NFWD*PREG_W-1:0] fwd_preg;
    logic [NFWD*XLEN-1:0]   fwd_data;
    logic [NSRC-1:0]        rf_rd_vld;
    logic [NSRC*PREG_W-1:0] rf_rd_preg;
    logic [NSRC*XLEN-1:0]   rf_rd_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic [IID_W-1:0]       out_iid;
    logic [6:0]             out_opcode, out_funct7;
    logic [2:0]             out_funct3;
    logic [PC_W-1:0]        out_pc;
    logic [NSRC-1:0]        out_psrc_vld;
    logic [NSRC*XLEN-1:0]   out_psrc_data;
    logic                   out_pdst_vld;
    logic [PREG_W-1:0]      out_pdst;
    logic                   out_imm_vld;
    logic [XLEN-1:0]        out_imm;
    logic                   wake_vld;
    logic [PREG_W-1:0]      wake_preg;

    always #5 clk = ~clk;

    idu_rf_stage dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_iid(in_iid), .in_opcode(in_opcode),
        .in_funct7(in_funct7), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_psrc_vld(in_psrc_vld), .in_psrc(in_psrc), .in_pdst_vld(in_pdst_vld),
        .in_pdst(in_pdst), .in_imm_vld(in_imm_vld), .in_imm(in_imm),
        .fwd_vld(fwd_vld), .fwd_preg(fwd_preg), .fwd_data(fwd_data),
        .rf_rd_vld(rf_rd_vld), .rf_rd_preg(rf_rd_preg), .rf_rd_data(rf_rd_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_iid(out_iid), .out_opcode(out_opcode),
        .out_funct7(out_funct7), .out_funct3(out_funct3), .out_pc(out_pc),
        .out_psrc_vld(out_psrc_vld), .out_psrc_data(out_psrc_data),
        .out_pdst_vld(out_pdst_vld), .out_pdst(out_pdst), .out_imm_vld(out_imm_vld),
        .out_imm(out_imm), .wake_vld(wake_vld), .wake_preg(wake_preg)
    );

    typedef struct packed {
        logic [IID_W-1:0]       iid;
        logic [6:0]             opcode;
        logic [6:0]             funct7;
        logic [2:0]             funct3;
        logic [PC_W-1:0]        pc;
        logic [NSRC-1:0]        psrc_vld;
        logic [NSRC*PREG_W-1:0] psrc;
        logic                   pdst_vld;
        logic [PREG_W-1:0]      pdst;
        logic                   imm_vld;
        logic [XLEN-1:0]        imm;
        logic [NSRC*XLEN-1:0]   data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_exp = 0;
    int   n_seen = 0;

    // Reference model: the instruction occupying the stage and its frozen operands.
    exp_t                 m_ins;
    logic                 m_vld = 1'b0;
    logic                 m_frozen = 1'b0;
    logic [NSRC*XLEN-1:0] m_frozen_val;

    function automatic logic [NSRC*XLEN-1:0] operands_now();
        logic [NSRC*XLEN-1:0] r;
        logic [XLEN-1:0]      v;
        logic                 found;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            v = rf_rd_data[i*XLEN +: XLEN];
            found = 1'b0;
            if (m_ins.psrc_vld[i]) begin
                for (int k = 0; k < NFWD; k++) begin
                    if (!found && fwd_vld[k] &&
                        fwd_preg[k*PREG_W +: PREG_W] == m_ins.psrc[i*PREG_W +: PREG_W]) begin
                        v = fwd_data[k*XLEN +: XLEN];
                        found = 1'b1;
                    end
                end
            end
            r[i*XLEN +: XLEN] = v;
        end
        return m_frozen ? m_frozen_val : r;
    endfunction

    task automatic set_idle();
        rtu_global_flush = 1'b0; in_vld = 1'b0; in_iid = '0; in_opcode = '0;
        in_funct7 = '0; in_funct3 = '0; in_pc = '0; in_psrc_vld = '0; in_psrc = '0;
        in_pdst_vld = 1'b0; in_pdst = '0; in_imm_vld = 1'b0; in_imm = '0;
        fwd_vld = '0; fwd_preg = '0; fwd_data = '0; rf_rd_data = '0; out_rdy = 1'b1;
    endtask

    task automatic load_inst(input logic [IID_W-1:0] iid, input logic [NSRC-1:0] sv,
                             input logic [PREG_W-1:0] p0, input logic dv);
        in_vld = 1'b1; in_iid = iid; in_opcode = 7'h33; in_funct7 = 7'h20;
        in_funct3 = 3'h5; in_pc = 64'h8000_0000 + 64'(iid) * 4; in_psrc_vld = sv;
        in_psrc = '0; in_psrc[0 +: PREG_W] = p0; in_psrc[PREG_W +: PREG_W] = PREG_W'(9);
        in_pdst_vld = dv; in_pdst = PREG_W'(iid) + PREG_W'(20);
        in_imm_vld = 1'b1; in_imm = 64'(iid) << 8;
    endtask

    task automatic rand_inputs();
        in_vld = ($urandom % 4) != 0;
        in_iid = IID_W'($urandom); in_opcode = 7'($urandom); in_funct7 = 7'($urandom);
        in_funct3 = 3'($urandom); in_pc = {$urandom, $urandom};
        in_psrc_vld = NSRC'($urandom);
        for (int i = 0; i < NSRC; i++) in_psrc[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
        in_pdst_vld = 1'($urandom); in_pdst = PREG_W'($urandom);
        in_imm_vld = 1'($urandom); in_imm = {$urandom, $urandom};
        fwd_vld = NFWD'($urandom) & NFWD'($urandom);
        for (int k = 0; k < NFWD; k++) begin
            fwd_preg[k*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
            fwd_data[k*XLEN +: XLEN] = {$urandom, $urandom};
        end
        for (int i = 0; i < NSRC; i++) rf_rd_data[i*XLEN +: XLEN] = {$urandom, $urandom};
        out_rdy = ($urandom % 3) != 0;
        rtu_global_flush = ($urandom % 40) == 0;
    endtask

    // Called at posedge+1 with this cycle's inputs driven; returns at the next posedge+1.
    task automatic step();
        exp_t e;
        logic exp_rdy;
        exp_rdy = !m_vld || out_rdy;
        #1;
        total++;
        if (in_rdy !== exp_rdy) begin
            bad++;
            $display("FAIL in_rdy got=%0b want=%0b at %0t", in_rdy, exp_rdy, $time);
        end
        if (m_vld && out_rdy) begin
            e = m_ins;
            e.data = operands_now();
            sb_q.push_back(e);
            n_exp++;
        end
        if (rtu_global_flush) begin
            m_vld = 1'b0; m_frozen = 1'b0;
        end else if (in_vld && exp_rdy) begin
            m_ins = '{iid: in_iid, opcode: in_opcode, funct7: in_funct7, funct3: in_funct3,
                      pc: in_pc, psrc_vld: in_psrc_vld, psrc: in_psrc, pdst_vld: in_pdst_vld,
                      pdst: in_pdst, imm_vld: in_imm_vld, imm: in_imm, data: '0};
            m_vld = 1'b1; m_frozen = 1'b0;
        end else if (m_vld && out_rdy) begin
            m_vld = 1'b0;
        end else if (m_vld && !m_frozen) begin
            m_frozen_val = operands_now();
            m_frozen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                n_seen++;
                total++;
                g = '{iid: out_iid, opcode: out_opcode, funct7: out_funct7, funct3: out_funct3,
                      pc: out_pc, psrc_vld: out_psrc_vld, psrc: rf_rd_preg, pdst_vld: out_pdst_vld,
                      pdst: out_pdst, imm_vld: out_imm_vld, imm: out_imm, data: out_psrc_data};
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_unexpected got iid=%0h pc=%h want no handoff", out_iid, out_pc);
                end else begin
                    e = sb_q.pop_front();
                    if (g !== e || rf_rd_vld !== e.psrc_vld) begin
                        bad++;
                        $display("FAIL xfer got iid=%0h pc=%h ops=%h rdv=%b want iid=%0h pc=%h ops=%h rdv=%b",
                                 g.iid, g.pc, g.data, rf_rd_vld, e.iid, e.pc, e.data, e.psrc_vld);
                    end else begin
                        $display("xfer iid=%0h pc=%h ops=%h ok", g.iid, g.pc, g.data);
                    end
                    total++;
                    if (wake_vld !== e.pdst_vld || (e.pdst_vld && wake_preg !== e.pdst)) begin
                        bad++;
                        $display("FAIL wake got vld=%0b preg=%0d want vld=%0b preg=%0d",
                                 wake_vld, wake_preg, e.pdst_vld, e.pdst);
                    end
                end
            end else begin
                total++;
                if (wake_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL wake_idle got=%0b want=0", wake_vld);
                end
                if (!out_vld) begin
                    total++;
                    if ({out_iid, out_opcode, out_funct7, out_funct3, out_pc, out_psrc_vld,
                         out_pdst_vld, out_pdst, out_imm_vld, out_imm, rf_rd_vld, rf_rd_preg} !== '0) begin
                        bad++;
                        $display("FAIL payload_idle got iid=%0h pc=%h pdst=%0d rdv=%b want all zero",
                                 out_iid, out_pc, out_pdst, rf_rd_vld);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || wake_vld !== 1'b0 || rf_rd_vld !== '0) begin
            bad++;
            $display("FAIL reset got vld=%0b rdy=%0b wake=%0b rdv=%b want 0/1/0/0",
                     out_vld, in_rdy, wake_vld, rf_rd_vld);
        end
        rst_clk = 1'b1;

        // RF operand, one-cycle latency.
        load_inst(4'h1, 2'b01, 6'd5, 1'b1); step();
        set_idle(); rf_rd_data[0 +: XLEN] = 64'h11; step();
        // Bus 2 beats bus 6 on the same preg.
        load_inst(4'h2, 2'b01, 6'd5, 1'b0); step();
        set_idle(); fwd_vld[2] = 1'b1; fwd_vld[6] = 1'b1;
        fwd_preg[2*PREG_W +: PREG_W] = 6'd5; fwd_preg[6*PREG_W +: PREG_W] = 6'd5;
        fwd_data[2*XLEN +: XLEN] = 64'hA; fwd_data[6*XLEN +: XLEN] = 64'hB; step();
        // Transient bypass captured on first stall cycle.
        load_inst(4'h3, 2'b01, 6'd5, 1'b1); step();
        set_idle(); out_rdy = 1'b0; fwd_vld[0] = 1'b1; fwd_preg[0 +: PREG_W] = 6'd5;
        fwd_data[0 +: XLEN] = 64'h77; step();
        set_idle(); out_rdy = 1'b0; step();
        set_idle(); out_rdy = 1'b0; fwd_vld[1] = 1'b1; fwd_preg[PREG_W +: PREG_W] = 6'd5;
        fwd_data[XLEN +: XLEN] = 64'hDEAD; step();
        set_idle(); step();
        // Invalid source ignores bypass.
        load_inst(4'h4, 2'b00, 6'd5, 1'b0); step();
        set_idle(); fwd_vld[0] = 1'b1; fwd_preg[0 +: PREG_W] = 6'd5;
        fwd_data[0 +: XLEN] = 64'h99; rf_rd_data[0 +: XLEN] = 64'h3; step();
        // Flush kills the resident instruction and drops the offered one.
        load_inst(4'h5, 2'b11, 6'd5, 1'b1); step();
        load_inst(4'h6, 2'b11, 6'd5, 1'b1); out_rdy = 1'b0; rtu_global_flush = 1'b1; step();
        set_idle(); step();
        // Back-to-back stream of four.
        for (int n = 0; n < 4; n++) begin
            load_inst(IID_W'(8 + n), 2'b11, PREG_W'(n), 1'(n % 2)); step();
        end
        set_idle(); step();
        // Asynchronous reset in the middle of a stall.
        load_inst(4'h7, 2'b01, 6'd5, 1'b1); step();
        set_idle(); out_rdy = 1'b0; step();
        set_idle(); out_rdy = 1'b0;
        #2 rst_clk = 1'b0;
        #1;
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset got vld=%0b rdy=%0b want 0/1", out_vld, in_rdy);
        end
        m_vld = 1'b0; m_frozen = 1'b0;
        @(posedge clk);
        #1 rst_clk = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end
        set_idle();
        repeat (3) step();
        total++;
        if (sb_q.size() != 0 || n_seen != n_exp) begin
            bad++;
            $display("FAIL handoff_count got=%0d want=%0d pending=%0d", n_seen, n_exp, sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idu_rf_stage.md
# idu_rf_stage

Parametrised register-file read stage for one issue pipe, between the IDU issue stage and an EXU pipe. Registers the issued instruction, drives its physical source indices to the register file, resolves operands from a priority bypass network of EX and CDB result buses, and adds a valid/ready handshake. Operands resolved on the first cycle of a downstream stall are captured so that transient bypass results are not lost.

## Interface
- XLEN, 64, operand/result width
- PREG_W, 6, physical register index width
- IID_W, 4, instruction id width
- NSRC, 2, number of source operands
- NFWD, 8, number of bypass buses; index 0 has the highest priority (EX buses first, then CDB)
- clk  in  1  clock
- rst_clk  in  1  asynchronous, active-low reset
- rtu_global_flush  in  1  kill the stage contents
- in_vld  in  1  issue offers an instruction
- in_rdy  out  1  stage accepts this cycle
- in_iid / in_opcode / in_funct7 / in_funct3 / in_pc  in  IID_W/7/7/3/64  instruction payload
- in_psrc_vld  in  NSRC  per-source valid
- in_psrc  in  NSRC*PREG_W  per-source physical index
- in_pdst_vld, in_pdst  in  1, PREG_W  destination
- in_imm_vld, in_imm  in  1, XLEN  immediate
- fwd_vld  in  NFWD  bypass bus valid
- fwd_preg  in  NFWD*PREG_W  bypass bus destination
- fwd_data  in  NFWD*XLEN  bypass bus result
- rf_rd_vld  out  NSRC  RF read enable (registered psrc_vld)
- rf_rd_preg  out  NSRC*PREG_W  RF read index (registered psrc)
- rf_rd_data  in  NSRC*XLEN  RF read data, same cycle as rf_rd_preg
- out_vld  out  1  instruction valid toward EXU
- out_rdy  in  1  EXU accepts
- out_iid / out_opcode / out_funct7 / out_funct3 / out_pc  out  as input  payload
- out_psrc_vld  out  NSRC  source valids
- out_psrc_data  out  NSRC*XLEN  resolved operands
- out_pdst_vld, out_pdst, out_imm_vld, out_imm  out  as input  destination/immediate
- wake_vld, wake_preg  out  1, PREG_W  destination announcement to issue

## Operation
- in_rdy = !out_vld | out_rdy (combinational).
- Load on in_vld & in_rdy: all payload registers take input, out_vld=1, capture flags cleared.
- out_vld & out_rdy & !(in_vld & in_rdy): bubble; out_vld=0, all payload registers cleared to zero.
- out_vld & !out_rdy: payload held; for each source not yet captured, cap_data[i] <= resolved value, cap_flag[i] <= 1.
- Resolved value, source i: cap_flag[i] ? cap_data[i] : (any fwd match ? data of lowest-index matching bus : rf_rd_data[i]). Match[k] = fwd_vld[k] & psrc_vld[i] & fwd_preg[k]==psrc[i].
- psrc_vld[i]=0: no forwarding; value passes rf_rd_data[i] (don't care downstream).
- wake_vld = out_vld & out_pdst_vld & out_rdy; wake_preg = out_pdst.
- rtu_global_flush: highest priority after reset; out_vld, payload, capture flags cleared next edge; any in_vld that cycle dropped; in_rdy stays as formula.

## Timing
- Reset: all outputs registered-zero; out_vld=0, rf_rd_vld=0, wake_vld=0, in_rdy=1.
- Latency: one cycle in_vld&in_rdy to out_vld; operands combinational within that cycle.
- Full throughput: back-to-back accepts with out_rdy held high.
- Stall: capture on the first stalled edge only; later bus activity ignored until unload.
- Simultaneous unload and load: new instruction loaded, no bubble, flags cleared.
- Reset mid-stall: captured state discarded asynchronously.

## Structure
- Package idu_rf_pkg: default XLEN, PREG_W, IID_W, NSRC, NFWD; payload struct typedef.
- Sub-module idu_rf_bypass_mux: one source, NFWD-way priority compare/select plus RF fallback; instantiated NSRC times by generate.

## Test plan
- Load psrc0=5 valid, no fwd, rf_rd_data0=0x11 -> out_psrc_data0=0x11, out_vld one cycle after accept.
- fwd_vld[2] and [6] both preg 5, data 0xA/0xB -> out_psrc_data0=0xA (index 2 wins).
- out_rdy=0, fwd[0] preg 5 data 0x77 in first stall cycle, then fwd gone, rf=0 -> output stays 0x77 until out_rdy=1.
- psrc_vld0=0, psrc0=5, fwd preg 5 data 0x99, rf=0x3 -> value 0x3.
- rtu_global_flush with out_vld=1 and in_vld=1 -> next cycle out_vld=0, payload zero, wake_vld=0.
- Streaming 4 instructions with out_rdy=1 -> 4 consecutive out_vld cycles, wake_vld asserted per pdst_vld instruction.
